// File: rtl/tt_sweep.sv
// tt_sweep: walks a combinational truth-table function through every input
// combination, samples its output after a settle delay, and scores the
// captured table against an expected vector latched at start.
module tt_sweep #(
    parameter int unsigned N_IN    = 3,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned REVERSE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 y,
    output logic [N_IN-1:0]      sel,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_bad,
    output logic                 bad_valid
);

    localparam int unsigned ROWS = 2**N_IN;
    localparam int unsigned WCW  = 4;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_IN-1:0]   idx;
    logic [WCW-1:0]    wcnt;
    logic [ROWS-1:0]   exp_q;

    logic              accept_c;
    logic              wait_done_c;
    logic              sample_c;
    logic              last_c;
    logic              miss_c;

    // Row index to select pattern; REVERSE serves functions wired MSB-first.
    function automatic logic [N_IN-1:0] map_sel(input logic [N_IN-1:0] i);
        logic [N_IN-1:0] r;
        r = i;
        if (REVERSE != 0) begin
            for (int b = 0; b < int'(N_IN); b++) begin
                r[b] = i[int'(N_IN) - 1 - b];
            end
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear aborts from any state and beats start.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_WAIT;
                S_WAIT:   if (wcnt == WAIT_LAST) state_nxt = S_SAMPLE;
                S_SAMPLE: state_nxt = (idx == IDX_LAST) ? S_IDLE : S_WAIT;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Decoded control strobes for the datapath.
    always_comb begin
        accept_c    = 1'b0;
        wait_done_c = 1'b0;
        sample_c    = 1'b0;
        last_c      = 1'b0;
        miss_c      = 1'b0;
        if (!clear) begin
            accept_c    = (state == S_IDLE) && start;
            wait_done_c = (state == S_WAIT) && (wcnt == WAIT_LAST);
            sample_c    = (state == S_SAMPLE);
            last_c      = sample_c && (idx == IDX_LAST);
            miss_c      = sample_c && (y != exp_q[idx]);
        end
    end

    // Sweep datapath: row stepping, capture, scoring and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            wcnt      <= '0;
            exp_q     <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            captured  <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            first_bad <= '0;
            bad_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                busy <= 1'b0;
                pass <= 1'b0;
            end else if (accept_c) begin
                exp_q     <= expected;
                idx       <= '0;
                wcnt      <= '0;
                sel       <= map_sel('0);
                captured  <= '0;
                err_count <= '0;
                first_bad <= '0;
                bad_valid <= 1'b0;
                pass      <= 1'b0;
                busy      <= 1'b1;
            end else if (state == S_WAIT) begin
                wcnt <= wait_done_c ? '0 : wcnt + 1'b1;
            end else if (sample_c) begin
                captured[idx] <= y;
                if (miss_c) begin
                    err_count <= err_count + 1'b1;
                    if (!bad_valid) begin
                        first_bad <= idx;
                        bad_valid <= 1'b1;
                    end
                end
                if (last_c) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == '0) && !miss_c;
                end else begin
                    idx <= idx + 1'b1;
                    sel <= map_sel(idx + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: drives a forward-wired and a reversed-wired tt_sweep side by
// side against a behavioural model of the whole sweep.
module tb_tt_sweep;

    localparam int N    = 3;
    localparam int S    = 1;
    localparam int ROWS = 8;
    localparam int RL   = ROWS * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic [7:0] expected;

    logic [2:0] sel  [2];
    logic       y    [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic       bv   [2];
    logic [7:0] cap  [2];
    logic [3:0] ec   [2];
    logic [2:0] fb   [2];

    int         checks = 0;
    int         errors = 0;
    int         mode   = 0;
    logic [7:0] rtab   = 8'h00;

    always #5 clk = ~clk;

    function automatic logic [2:0] rev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // Function under sweep: 0 xor3, 1 sel[2], 2 const 0, else random table.
    function automatic logic yfun(input int m, input logic [2:0] s, input logic [7:0] t);
        case (m)
            0:       return ^s;
            1:       return s[2];
            2:       return 1'b0;
            default: return t[s];
        endcase
    endfunction

    always_comb begin
        y[0] = yfun(mode, sel[0], rtab);
        y[1] = yfun(mode, sel[1], rtab);
    end

    tt_sweep #(.N_IN(N), .SETTLE(S), .REVERSE(0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .expected(expected), .y(y[0]), .sel(sel[0]), .busy(busy[0]),
        .done(done[0]), .captured(cap[0]), .pass(pass[0]),
        .err_count(ec[0]), .first_bad(fb[0]), .bad_valid(bv[0])
    );

    tt_sweep #(.N_IN(N), .SETTLE(S), .REVERSE(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .expected(expected), .y(y[1]), .sel(sel[1]), .busy(busy[1]),
        .done(done[1]), .captured(cap[1]), .pass(pass[1]),
        .err_count(ec[1]), .first_bad(fb[1]), .bad_valid(bv[1])
    );

    // Reference: what the first n rows of a sweep should yield.
    task automatic model_run(input int rev, input int n, input logic [7:0] e,
                             output logic [7:0] cm, output int errs,
                             output int fbm, output logic pm);
        logic [2:0] s;
        logic       yb;
        cm   = 8'h00;
        errs = 0;
        fbm  = -1;
        for (int i = 0; i < n; i++) begin
            s     = (rev != 0) ? rev3(3'(i)) : 3'(i);
            yb    = yfun(mode, s, rtab);
            cm[i] = yb;
            if (yb != e[i]) begin
                errs++;
                if (fbm < 0) fbm = i;
            end
        end
        if (fbm < 0) fbm = 0;
        pm = (n == ROWS) && (errs == 0);
    endtask

    task automatic check_results(input string name, input logic [7:0] e, input int n);
        logic [7:0] cm;
        int         errs;
        int         fbm;
        logic       pm;
        logic [4:0] st_m;
        for (int d = 0; d < 2; d++) begin
            model_run(d, n, e, cm, errs, fbm, pm);
            st_m = {pm, (errs > 0), 3'(fbm)};
            checks++;
            if (cap[d] !== cm) begin
                errors++;
                $display("FAIL %s captured dut%0d got %h want %h", name, d, cap[d], cm);
            end
            checks++;
            if (ec[d] !== 4'(errs)) begin
                errors++;
                $display("FAIL %s err_count dut%0d got %0d want %0d", name, d, ec[d], errs);
            end
            checks++;
            if ({pass[d], bv[d], fb[d]} !== st_m) begin
                errors++;
                $display("FAIL %s pass/bad_valid/first_bad dut%0d got %b want %b",
                         name, d, {pass[d], bv[d], fb[d]}, st_m);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sel[d], busy[d], done[d], pass[d], bv[d], cap[d], ec[d], fb[d]} !== 27'd0) begin
                errors++;
                $display("FAIL %s dut%0d outputs got %h want 0", name, d,
                         {sel[d], busy[d], done[d], pass[d], bv[d], cap[d], ec[d], fb[d]});
            end
        end
    endtask

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic start_sweep(input logic [7:0] e);
        expected = e;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Observe a sweep for a fixed window; optionally poke start at step poke_k.
    task automatic watch_sweep(input int poke_k, output int busy_n, output int done_k,
                               output int done_n, output int odd);
        int row;
        busy_n = 0;
        done_k = -1;
        done_n = 0;
        odd    = 0;
        for (int k = 0; k < RL + 4; k++) begin
            row = (k / 2 > ROWS - 1) ? ROWS - 1 : k / 2;
            if (busy[0]) busy_n++;
            if (done[0]) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (busy[1] !== busy[0] || done[1] !== done[0]) odd++;
            if (sel[0] !== 3'(row) || sel[1] !== rev3(3'(row))) odd++;
            start = (k == poke_k);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_timing(input string name, input int busy_n, input int done_k,
                                input int done_n, input int odd);
        checks++;
        if (busy_n != RL) begin
            errors++;
            $display("FAIL %s busy cycles got %0d want %0d", name, busy_n, RL);
        end
        checks++;
        if (done_k != RL || done_n != 1) begin
            errors++;
            $display("FAIL %s done at step %0d count %0d want step %0d count 1",
                     name, done_k, done_n, RL);
        end
        checks++;
        if (odd != 0) begin
            errors++;
            $display("FAIL %s sel/handshake deviations got %0d want 0", name, odd);
        end
    endtask

    task automatic run_check(input string name, input logic [7:0] e, input int poke_k);
        int busy_n, done_k, done_n, odd;
        start_sweep(e);
        watch_sweep(poke_k, busy_n, done_k, done_n, odd);
        check_timing(name, busy_n, done_k, done_n, odd);
        check_results(name, e, ROWS);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        expected = 8'h00;
        mode     = 0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        mode = 0;
        run_check("xor_match", 8'h96, -1);
    endtask

    task automatic test_mismatch();
        mode = 0;
        run_check("xor_miss", 8'h97, -1);
        checks++;
        if ({cap[0], ec[0], fb[0], bv[0], pass[0]} !== {8'h96, 4'd1, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL xor_miss_const got %h want %h",
                     {cap[0], ec[0], fb[0], bv[0], pass[0]}, {8'h96, 4'd1, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_bit_order();
        mode = 1;
        run_check("bit_order", 8'hAA, -1);
        checks++;
        if (cap[0] !== 8'hF0 || cap[1] !== 8'hAA) begin
            errors++;
            $display("FAIL bit_order_const got fwd %h rev %h want F0 AA", cap[0], cap[1]);
        end
    endtask

    task automatic test_clear();
        int dn;
        mode = 0;
        start_sweep(8'h97);
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || done[0] !== 1'b0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL clear_abort busy %b%b done %b%b want 0000",
                     busy[0], busy[1], done[0], done[1]);
        end
        check_results("clear_partial", 8'h97, 3);
        dn = 0;
        for (int k = 0; k < RL + 4; k++) begin
            if (done[0] || done[1]) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL clear_no_done got %0d done cycles want 0", dn);
        end
        run_check("after_clear", 8'h96, -1);
    endtask

    task automatic test_busy_start();
        mode = 0;
        run_check("start_while_busy", 8'h96, 4);
    endtask

    task automatic test_back_to_back();
        int         n;
        int         busy_n, done_k, done_n, odd;
        logic [7:0] e1;
        logic [7:0] e2;
        mode = 3;
        rtab = 8'($urandom);
        e1   = 8'($urandom);
        e2   = ~e1;
        start_sweep(e1);
        n = 0;
        while (!done[0] && n < 4 * RL) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done[0]) begin
            errors++;
            $display("FAIL b2b_done_wait got no done within %0d cycles", 4 * RL);
        end
        check_results("b2b_first", e1, ROWS);
        start_sweep(e2);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], pass[d], bv[d], cap[d], ec[d], fb[d]} !== {1'b1, 18'd0}) begin
                errors++;
                $display("FAIL b2b_restart dut%0d got %h want %h", d,
                         {busy[d], done[d], pass[d], bv[d], cap[d], ec[d], fb[d]}, {1'b1, 18'd0});
            end
        end
        watch_sweep(-1, busy_n, done_k, done_n, odd);
        check_timing("b2b_second", busy_n, done_k, done_n, odd);
        check_results("b2b_second", e2, ROWS);
    endtask

    task automatic test_random();
        logic [7:0] cm;
        logic [7:0] e;
        int         errs, fbm;
        logic       pm;
        mode = 3;
        for (int it = 0; it < 8; it++) begin
            rtab = 8'($urandom);
            model_run(0, ROWS, 8'h00, cm, errs, fbm, pm);
            case ($urandom_range(0, 2))
                0:       e = cm;
                1:       e = cm ^ (8'h01 << $urandom_range(0, 7));
                default: e = 8'($urandom);
            endcase
            run_check("random", e, -1);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        mode = 2;
        start_sweep(8'hFF);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done[0] || done[1] || busy[0] || busy[1]) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL reset_mid_idle got %0d active cycles want 0", dn);
        end
        run_check("zero_all_miss", 8'hFF, -1);
        checks++;
        if ({ec[0], fb[0], pass[0]} !== {4'd8, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_all_miss_const got %h want %h",
                     {ec[0], fb[0], pass[0]}, {4'd8, 3'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_bit_order();
        test_clear();
        test_busy_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep.md
Name: tt_sweep

Overview:
- Sequential stimulus/capture stage placed directly upstream of the combinational mux-based truth-table functions (2:1/4:1/8:1 implementations).
- Drives the function's select inputs through every input combination and samples the function output Y after a settle delay.
- Assembles the captured truth table and compares it against an expected vector.
- Reports pass/fail, the mismatch count and the first failing index, with a start/done handshake.

Parameters:
- N_IN, 3, number of function inputs; the table has 2**N_IN rows (legal 1..4).
- SETTLE, 1, idle cycles per row between driving `sel` and sampling `y` (legal 1..15).
- REVERSE, 0, when 1, `sel` bit order is reversed so that idx[0] drives sel[N_IN-1]. This covers functions wired with (C,B,A) order.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; accepted only in IDLE.
- clear  input  1  synchronous abort; returns to IDLE with no done pulse.
- expected  input  2**N_IN  expected table; bit i is the Y value for row index i; latched when start is accepted.
- y  input  1  output of the function under sweep.
- sel  output  N_IN  drive to the function select/data inputs (sel[0] = S0/A when REVERSE=0).
- busy  output  1  high from start acceptance until the last sample edge.
- done  output  1  one-cycle pulse after the sweep completes.
- captured  output  2**N_IN  sampled table; bit i is y sampled for row i.
- pass  output  1  captured == latched expected; valid when done pulses, then held.
- err_count  output  N_IN+1  number of mismatching rows.
- first_bad  output  N_IN  lowest mismatching row index.
- bad_valid  output  1  at least one mismatch recorded.

Behaviour:
- Async reset (rst_n=0): state IDLE; idx, wait counter and sel = 0; busy, done, pass, bad_valid = 0; captured, err_count, first_bad = 0; expected latch = 0.
- State machine: IDLE, WAIT, SAMPLE.
- IDLE, on edge with start=1 and clear=0:
  - Latch expected; idx=0; wait counter=0.
  - Clear captured, err_count, first_bad, bad_valid and pass.
  - Enter WAIT; busy=1.
- WAIT: sel = idx (bit-reversed if REVERSE=1). After SETTLE edges, enter SAMPLE.
- SAMPLE, on its edge:
  - captured[idx] <= y.
  - If y != exp_q[idx]: err_count increments; if bad_valid=0, first_bad <= idx and bad_valid <= 1.
  - If idx < 2**N_IN-1: idx increments, return to WAIT.
  - Else: go to IDLE; busy=0; done=1 for exactly the following cycle.
  - pass <= 1 iff no row mismatched, including this final row.
- Timing: each row takes SETTLE+1 edges. For start accepted at edge e0, row i is sampled at edge e0+(i+1)(SETTLE+1). done is high in the cycle after edge e0+2**N_IN*(SETTLE+1).
- sel is stable for all SETTLE+1 cycles of a row and changes only on the edge following a SAMPLE.
- In IDLE, sel holds its last value. After a full sweep, sel = 2**N_IN-1.
- start while busy: ignored, no effect on the sweep.
- start in the same cycle as done=1: accepted (state is IDLE). Results clear; done still drops next cycle.
- clear (any state, synchronous): go to IDLE; busy=0; no done pulse.
  - captured, err_count, first_bad and bad_valid keep their partial values.
  - pass forced to 0.
  - clear has priority over start in the same cycle.
- Reset mid-sweep: everything returns to reset values immediately; no done pulse.
- err_count never wraps; its maximum is 2**N_IN, which fits N_IN+1 bits.
- Result outputs hold from done until the next accepted start or clear.

Test Plan:
- N_IN=3, SETTLE=1, REVERSE=0; bench models y = sel[0]^sel[1]^sel[2]; expected=8'h96; start pulse → busy for 16 cycles, done at cycle 17, captured=8'h96, pass=1, err_count=0, bad_valid=0.
- Same y model, expected=8'h97 → pass=0, err_count=1, first_bad=0, bad_valid=1; captured=8'h96.
- REVERSE=1, y = sel[2] (i.e. idx[0]) → captured=8'hAA; with REVERSE=0, same y → captured=8'hF0. Also check that sel is held constant over each 2-cycle row.
- Assert clear at cycle 7 of a sweep → busy=0 next cycle, no done pulse, pass=0, captured bits 0..2 populated and upper bits 0. Then start again → full result as in the first scenario.
- Pulse start while busy at cycle 5 → ignored, single done at cycle 17. Assert start during the done cycle → new sweep begins, results cleared.
- Drop rst_n at cycle 9 mid-sweep → all outputs 0 asynchronously (before the next edge), state IDLE. With y tied 0 and expected=8'hFF → err_count=8, first_bad=0, pass=0.
